// File: rtl/if_fetch_queue_if.sv
// Bus bundle between the fetch queue and its environment: the redirect input,
// the SRAM-like instruction port and the hand-off to the ID stage.
// The master modport is the fetch queue's view; slave is the environment's view.
interface if_fetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  logic        ds_allow_in;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_ex_adef;

  modport master (
    input  redirect_valid, redirect_pc,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  ds_allow_in,
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
    output inst_sram_addr, inst_sram_wdata,
    output fs_to_ds_valid, fs_pc, fs_inst, fs_ex_adef
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output ds_allow_in,
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
    input  inst_sram_addr, inst_sram_wdata,
    input  fs_to_ds_valid, fs_pc, fs_inst, fs_ex_adef
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Multi-outstanding instruction fetch front end.
// Keeps up to MAX_OUTSTANDING reads in flight, stores returned instructions in
// an in-order buffer for ID, and silently drops every response that belongs to
// requests issued before a redirect. Issue is credit-limited so that every
// live in-flight request is guaranteed a buffer slot when its data returns.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'h1C000000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          IBUF_DEPTH      = 4
) (
  input logic            clk,
  input logic            reset,
  if_fetch_queue_if.master bus
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = $clog2(IBUF_DEPTH + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int QW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;

  logic [31:0]   r_fetchPc;
  logic          r_halted;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_cancelCnt;

  logic [31:0]   r_pcFifo [MAX_OUTSTANDING];
  logic [PW-1:0] r_pcWrPtr;
  logic [PW-1:0] r_pcRdPtr;

  logic [31:0]   r_ibufPc   [IBUF_DEPTH];
  logic [31:0]   r_ibufInst [IBUF_DEPTH];
  logic          r_ibufAdef [IBUF_DEPTH];
  logic [QW-1:0] r_ibufWrPtr;
  logic [QW-1:0] r_ibufRdPtr;
  logic [BW-1:0] r_ibufCount;

  logic          w_aligned;
  int            w_live;
  logic          w_ibufFull;
  logic          w_req;
  logic          w_accept;
  logic          w_resp;
  logic          w_drop;
  logic          w_respPush;
  logic          w_adef;
  logic          w_ibufPush;
  logic          w_ibufPop;
  logic          w_valid;
  logic [31:0]   w_pushPc;
  logic [31:0]   w_pushInst;
  logic [PW-1:0] w_pcWrNext;
  logic [PW-1:0] w_pcRdNext;
  logic [QW-1:0] w_ibufWrNext;
  logic [QW-1:0] w_ibufRdNext;

  // Issue credit, response classification and ADEF detection.
  always_comb begin
    w_aligned  = (r_fetchPc[1:0] == 2'b00);
    w_live     = int'(r_inflight) - int'(r_cancelCnt);
    w_ibufFull = (r_ibufCount == BW'(IBUF_DEPTH));
    w_req      = ~reset & ~bus.redirect_valid & ~r_halted & w_aligned
                 & (int'(r_inflight) < MAX_OUTSTANDING)
                 & ((w_live + int'(r_ibufCount)) < IBUF_DEPTH);
    w_accept   = w_req & bus.inst_sram_addr_ok;
    w_resp     = bus.inst_sram_data_ok & (r_inflight != '0);
    w_drop     = w_resp & ((r_cancelCnt != '0) | bus.redirect_valid);
    w_respPush = w_resp & ~w_drop;
    w_adef     = ~w_aligned & ~r_halted & (w_live == 0) & ~w_ibufFull
                 & ~bus.redirect_valid;
    w_ibufPush = w_respPush | w_adef;
    w_valid    = (r_ibufCount != '0);
    w_ibufPop  = w_valid & bus.ds_allow_in & ~bus.redirect_valid;
    w_pushPc   = w_adef ? r_fetchPc : r_pcFifo[r_pcRdPtr];
    w_pushInst = w_adef ? 32'h0 : bus.inst_sram_rdata;
    w_pcWrNext   = (r_pcWrPtr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_pcWrPtr + PW'(1);
    w_pcRdNext   = (r_pcRdPtr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_pcRdPtr + PW'(1);
    w_ibufWrNext = (r_ibufWrPtr == QW'(IBUF_DEPTH - 1)) ? '0 : r_ibufWrPtr + QW'(1);
    w_ibufRdNext = (r_ibufRdPtr == QW'(IBUF_DEPTH - 1)) ? '0 : r_ibufRdPtr + QW'(1);
  end

  assign bus.inst_sram_req   = w_req;
  assign bus.inst_sram_wr    = 1'b0;
  assign bus.inst_sram_size  = 2'b10;
  assign bus.inst_sram_wstrb = 4'h0;
  assign bus.inst_sram_addr  = r_fetchPc;
  assign bus.inst_sram_wdata = 32'h0;

  assign bus.fs_to_ds_valid = w_valid;
  assign bus.fs_pc          = w_valid ? r_ibufPc[r_ibufRdPtr]   : 32'h0;
  assign bus.fs_inst        = w_valid ? r_ibufInst[r_ibufRdPtr] : 32'h0;
  assign bus.fs_ex_adef     = w_valid ? r_ibufAdef[r_ibufRdPtr] : 1'b0;

  // Fetch address and halt flag: redirect restarts, ADEF parks fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetchPc <= RESET_PC;
      r_halted  <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_fetchPc <= bus.redirect_pc;
      r_halted  <= 1'b0;
    end else begin
      if (w_accept) r_fetchPc <= r_fetchPc + 32'd4;
      if (w_adef)   r_halted  <= 1'b1;
    end
  end

  // PC FIFO and in-flight count track accepted requests in issue order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_pcFifo[i] <= '0;
      r_pcWrPtr  <= '0;
      r_pcRdPtr  <= '0;
      r_inflight <= '0;
    end else begin
      if (w_accept) begin
        r_pcFifo[r_pcWrPtr] <= r_fetchPc;
        r_pcWrPtr           <= w_pcWrNext;
      end
      if (w_resp) r_pcRdPtr <= w_pcRdNext;
      if (w_accept && !w_resp)      r_inflight <= r_inflight + CW'(1);
      else if (!w_accept && w_resp) r_inflight <= r_inflight - CW'(1);
    end
  end

  // Stale-response counter: loaded on redirect with requests still owed after this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cancelCnt <= '0;
    end else if (bus.redirect_valid) begin
      r_cancelCnt <= w_resp ? (r_inflight - CW'(1)) : r_inflight;
    end else if (w_drop && (r_cancelCnt != '0)) begin
      r_cancelCnt <= r_cancelCnt - CW'(1);
    end
  end

  // In-order instruction buffer: one push (response or ADEF) and one pop per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < IBUF_DEPTH; i++) begin
        r_ibufPc[i]   <= '0;
        r_ibufInst[i] <= '0;
        r_ibufAdef[i] <= 1'b0;
      end
      r_ibufWrPtr <= '0;
      r_ibufRdPtr <= '0;
      r_ibufCount <= '0;
    end else if (bus.redirect_valid) begin
      r_ibufWrPtr <= '0;
      r_ibufRdPtr <= '0;
      r_ibufCount <= '0;
    end else begin
      if (w_ibufPush) begin
        r_ibufPc[r_ibufWrPtr]   <= w_pushPc;
        r_ibufInst[r_ibufWrPtr] <= w_pushInst;
        r_ibufAdef[r_ibufWrPtr] <= w_adef;
        r_ibufWrPtr             <= w_ibufWrNext;
      end
      if (w_ibufPop) r_ibufRdPtr <= w_ibufRdNext;
      if (w_ibufPush && !w_ibufPop)      r_ibufCount <= r_ibufCount + BW'(1);
      else if (!w_ibufPush && w_ibufPop) r_ibufCount <= r_ibufCount - BW'(1);
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed testbench for if_fetch_queue. A small in-order memory model answers
// every accepted request one cycle later with data = ~address, so the expected
// instruction for any delivered PC is simply its bitwise inverse.
module tb_if_fetch_queue;

  logic clk = 1'b0;
  logic reset;

  if_fetch_queue_if bus ();

  if_fetch_queue #(
    .RESET_PC       (32'h1C000000),
    .MAX_OUTSTANDING(2),
    .IBUF_DEPTH     (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          acceptCnt = 0;
  bit          autoData = 1'b0;
  logic [31:0] memQ [$];

  // Present the head of the memory response queue when responses are enabled.
  task automatic driveMem();
    if (autoData && memQ.size() > 0) begin
      bus.inst_sram_data_ok = 1'b1;
      bus.inst_sram_rdata   = ~memQ[0];
    end else begin
      bus.inst_sram_data_ok = 1'b0;
      bus.inst_sram_rdata   = 32'h0;
    end
  endtask

  // Advance one clock: record handshakes, then update memory outputs at negedge.
  task automatic step();
    #1;
    if (bus.inst_sram_req && bus.inst_sram_addr_ok) begin
      memQ.push_back(bus.inst_sram_addr);
      acceptCnt++;
    end
    if (bus.inst_sram_data_ok && memQ.size() > 0) void'(memQ.pop_front());
    @(posedge clk);
    @(negedge clk);
    driveMem();
    #1;
  endtask

  task automatic redirectTo(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    step();
    bus.redirect_valid = 1'b0;
    #1;
  endtask

  task automatic drain();
    bus.inst_sram_addr_ok = 1'b0;
    bus.ds_allow_in       = 1'b1;
    autoData              = 1'b1;
    driveMem();
    repeat (6) step();
  endtask

  task automatic test_reset();
    reset                 = 1'b1;
    bus.redirect_valid    = 1'b0;
    bus.redirect_pc       = 32'h0;
    bus.inst_sram_addr_ok = 1'b0;
    bus.inst_sram_data_ok = 1'b0;
    bus.inst_sram_rdata   = 32'h0;
    bus.ds_allow_in       = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (bus.inst_sram_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b exp 0", bus.inst_sram_req); end
    checks++; if (bus.inst_sram_addr !== 32'h1C000000) begin errors++; $display("[TB] FAIL reset_addr got %h exp 1c000000", bus.inst_sram_addr); end
    checks++; if (bus.fs_to_ds_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", bus.fs_to_ds_valid); end
    checks++; if (bus.fs_pc !== 32'h0 || bus.fs_inst !== 32'h0 || bus.fs_ex_adef !== 1'b0) begin errors++; $display("[TB] FAIL reset_head got pc=%h inst=%h adef=%b exp 0", bus.fs_pc, bus.fs_inst, bus.fs_ex_adef); end
    checks++; if (bus.inst_sram_wr !== 1'b0 || bus.inst_sram_size !== 2'b10 || bus.inst_sram_wstrb !== 4'h0 || bus.inst_sram_wdata !== 32'h0) begin errors++; $display("[TB] FAIL const_outputs got wr=%b size=%b wstrb=%h wdata=%h", bus.inst_sram_wr, bus.inst_sram_size, bus.inst_sram_wstrb, bus.inst_sram_wdata); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.inst_sram_req !== 1'b1) begin errors++; $display("[TB] FAIL release_req got %b exp 1", bus.inst_sram_req); end
  endtask

  task automatic test_stream();
    logic [31:0] expPc;
    bus.inst_sram_addr_ok = 1'b1;
    bus.ds_allow_in       = 1'b1;
    autoData              = 1'b1;
    driveMem();
    #1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== 32'h1C000000 + 32'(4 * k)) begin
        errors++; $display("[TB] FAIL stream_issue k=%0d got req=%b addr=%h exp req=1 addr=%h", k, bus.inst_sram_req, bus.inst_sram_addr, 32'h1C000000 + 32'(4 * k));
      end
      if (k >= 2) begin
        expPc = 32'h1C000000 + 32'(4 * (k - 2));
        checks++;
        if (bus.fs_to_ds_valid !== 1'b1 || bus.fs_pc !== expPc || bus.fs_inst !== ~expPc || bus.fs_ex_adef !== 1'b0) begin
          errors++; $display("[TB] FAIL stream_deliver k=%0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h", k, bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst, expPc, ~expPc);
        end
      end
      step();
    end
    drain();
  endtask

  task automatic test_outstanding_limit();
    int startCnt;
    bus.ds_allow_in       = 1'b1;
    bus.inst_sram_addr_ok = 1'b1;
    autoData              = 1'b0;
    driveMem();
    redirectTo(32'h1C000000);
    startCnt = acceptCnt;
    checks++; if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== 32'h1C000000) begin errors++; $display("[TB] FAIL limit_first got req=%b addr=%h exp 1 1c000000", bus.inst_sram_req, bus.inst_sram_addr); end
    step();
    checks++; if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== 32'h1C000004) begin errors++; $display("[TB] FAIL limit_second got req=%b addr=%h exp 1 1c000004", bus.inst_sram_req, bus.inst_sram_addr); end
    step();
    checks++; if (bus.inst_sram_req !== 1'b0) begin errors++; $display("[TB] FAIL limit_block got req=%b exp 0", bus.inst_sram_req); end
    step();
    checks++; if (bus.inst_sram_req !== 1'b0 || acceptCnt - startCnt != 2) begin errors++; $display("[TB] FAIL limit_hold got req=%b accepted=%0d exp 0 2", bus.inst_sram_req, acceptCnt - startCnt); end
    autoData = 1'b1;
    driveMem();
    #1;
    checks++; if (bus.inst_sram_req !== 1'b0) begin errors++; $display("[TB] FAIL limit_dataok_cycle got req=%b exp 0", bus.inst_sram_req); end
    step();
    checks++; if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== 32'h1C000008) begin errors++; $display("[TB] FAIL limit_resume got req=%b addr=%h exp 1 1c000008", bus.inst_sram_req, bus.inst_sram_addr); end
    checks++; if (bus.fs_to_ds_valid !== 1'b1 || bus.fs_pc !== 32'h1C000000) begin errors++; $display("[TB] FAIL limit_deliver got v=%b pc=%h exp 1 1c000000", bus.fs_to_ds_valid, bus.fs_pc); end
    drain();
  endtask

  task automatic test_backpressure();
    int startCnt;
    logic [31:0] expPc;
    bus.ds_allow_in       = 1'b0;
    bus.inst_sram_addr_ok = 1'b1;
    autoData              = 1'b1;
    redirectTo(32'h1C000300);
    startCnt = acceptCnt;
    repeat (8) step();
    checks++; if (acceptCnt - startCnt != 4) begin errors++; $display("[TB] FAIL bp_credit got accepted=%0d exp 4", acceptCnt - startCnt); end
    checks++; if (bus.inst_sram_req !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_low got %b exp 0", bus.inst_sram_req); end
    bus.ds_allow_in = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      expPc = 32'h1C000300 + 32'(4 * i);
      checks++;
      if (bus.fs_to_ds_valid !== 1'b1 || bus.fs_pc !== expPc || bus.fs_inst !== ~expPc) begin
        errors++; $display("[TB] FAIL bp_order i=%0d got v=%b pc=%h inst=%h exp pc=%h", i, bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst, expPc);
      end
      step();
    end
    drain();
  endtask

  task automatic waitFirst(input string name, input logic [31:0] expPc);
    bit found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (bus.fs_to_ds_valid === 1'b1) begin
        found = 1'b1;
        checks++;
        if (bus.fs_pc !== expPc || bus.fs_inst !== ~expPc) begin
          errors++; $display("[TB] FAIL %s got pc=%h inst=%h exp pc=%h inst=%h", name, bus.fs_pc, bus.fs_inst, expPc, ~expPc);
        end
      end else begin
        step();
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("[TB] FAIL %s_timeout got no delivery exp pc=%h", name, expPc);
    end
  endtask

  task automatic test_redirect();
    bus.ds_allow_in       = 1'b1;
    bus.inst_sram_addr_ok = 1'b1;
    autoData              = 1'b0;
    driveMem();
    redirectTo(32'h1C000400);
    step();
    step();
    checks++; if (bus.inst_sram_req !== 1'b0) begin errors++; $display("[TB] FAIL redir_two_inflight got req=%b exp 0", bus.inst_sram_req); end
    redirectTo(32'h1C000100);
    autoData = 1'b1;
    driveMem();
    #1;
    checks++; if (bus.inst_sram_req !== 1'b0 || bus.inst_sram_addr !== 32'h1C000100) begin errors++; $display("[TB] FAIL redir_after got req=%b addr=%h exp 0 1c000100", bus.inst_sram_req, bus.inst_sram_addr); end
    waitFirst("redir_first", 32'h1C000100);
    drain();
  endtask

  task automatic test_redirect_with_data();
    bus.ds_allow_in       = 1'b1;
    bus.inst_sram_addr_ok = 1'b1;
    autoData              = 1'b0;
    driveMem();
    redirectTo(32'h1C000500);
    step();
    step();
    autoData = 1'b1;
    driveMem();
    redirectTo(32'h1C000600);
    checks++; if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== 32'h1C000600) begin errors++; $display("[TB] FAIL redir_data_req got req=%b addr=%h exp 1 1c000600", bus.inst_sram_req, bus.inst_sram_addr); end
    waitFirst("redir_data_first", 32'h1C000600);
    drain();
  endtask

  task automatic test_adef();
    int startCnt;
    bus.ds_allow_in       = 1'b0;
    bus.inst_sram_addr_ok = 1'b1;
    autoData              = 1'b1;
    startCnt              = acceptCnt;
    redirectTo(32'h1C000102);
    checks++; if (bus.inst_sram_req !== 1'b0 || bus.fs_to_ds_valid !== 1'b0) begin errors++; $display("[TB] FAIL adef_first got req=%b v=%b exp 0 0", bus.inst_sram_req, bus.fs_to_ds_valid); end
    step();
    checks++;
    if (bus.fs_to_ds_valid !== 1'b1 || bus.fs_pc !== 32'h1C000102 || bus.fs_inst !== 32'h0 || bus.fs_ex_adef !== 1'b1) begin
      errors++; $display("[TB] FAIL adef_entry got v=%b pc=%h inst=%h adef=%b exp 1 1c000102 0 1", bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst, bus.fs_ex_adef);
    end
    repeat (3) step();
    checks++; if (bus.inst_sram_req !== 1'b0 || bus.fs_pc !== 32'h1C000102) begin errors++; $display("[TB] FAIL adef_hold got req=%b pc=%h exp 0 1c000102", bus.inst_sram_req, bus.fs_pc); end
    bus.ds_allow_in = 1'b1;
    #1;
    step();
    checks++; if (bus.fs_to_ds_valid !== 1'b0 || bus.inst_sram_req !== 1'b0) begin errors++; $display("[TB] FAIL adef_single got v=%b req=%b exp 0 0", bus.fs_to_ds_valid, bus.inst_sram_req); end
    repeat (3) step();
    checks++; if (bus.fs_to_ds_valid !== 1'b0 || acceptCnt - startCnt != 0) begin errors++; $display("[TB] FAIL adef_halted got v=%b accepted=%0d exp 0 0", bus.fs_to_ds_valid, acceptCnt - startCnt); end
    redirectTo(32'h1C000200);
    checks++; if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== 32'h1C000200) begin errors++; $display("[TB] FAIL adef_resume got req=%b addr=%h exp 1 1c000200", bus.inst_sram_req, bus.inst_sram_addr); end
    waitFirst("adef_resume_first", 32'h1C000200);
    drain();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_outstanding_limit();
    test_backpressure();
    test_redirect();
    test_redirect_with_data();
    test_adef();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch front end. It replaces the single-outstanding fetch stage with a multi-outstanding one: up to MAX_OUTSTANDING requests in flight on the SRAM-like instruction port, returned instructions held in an IBUF_DEPTH-entry in-order buffer, and any number of stale responses discarded after a redirect, where the previous stage could discard only one. It sits between the redirect logic (exception, ertn, branch and TLB refetch, already merged upstream into one redirect) and the ID stage.

## Interface
- RESET_PC, 32'h1C000000, first fetch address after reset
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests (≥1)
- IBUF_DEPTH, 4, instruction buffer entries (≥1)

Ports:
- clk  in  1  clock; one clock only, all state on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address
- inst_sram_req  out  1  request valid
- inst_sram_wr  out  1  constant 0
- inst_sram_size  out  2  constant 2'b10
- inst_sram_wstrb  out  4  constant 0
- inst_sram_addr  out  32  equals fetch_pc
- inst_sram_wdata  out  32  constant 0
- inst_sram_addr_ok  in  1  request accepted
- inst_sram_data_ok  in  1  read data valid; responses arrive in request order
- inst_sram_rdata  in  32  read data
- ds_allow_in  in  1  ID accepts this cycle
- fs_to_ds_valid  out  1  buffer head valid
- fs_pc  out  32  PC of the buffer head
- fs_inst  out  32  instruction of the buffer head
- fs_ex_adef  out  1  buffer head carries an ADEF fetch exception

## Operation

**State**
- fetch_pc: 32 bits.
- inflight: count of accepted requests not yet answered; width clog2(MAX_OUTSTANDING+1).
- cancel_cnt: count of stale responses still to be dropped; same width as inflight.
- pc_fifo: MAX_OUTSTANDING entries holding the PC of each in-flight request.
- ibuf: IBUF_DEPTH entries of {pc, inst, adef}, plus occupancy count.
- halted: 1 bit.

**Issue rule**
- inst_sram_req = ~redirect_valid & ~halted & (fetch_pc[1:0]==0) & (inflight < MAX_OUTSTANDING) & ((inflight − cancel_cnt) + ibuf_count < IBUF_DEPTH).
- This credit check guarantees that ibuf never overflows.
- On req & addr_ok: push fetch_pc into pc_fifo, increment inflight, fetch_pc += 4 (32-bit wrap).

**Response**
- On data_ok: pop pc_fifo and decrement inflight.
- If cancel_cnt ≠ 0 or redirect_valid is high: decrement cancel_cnt (saturating at 0) and discard the data.
- Otherwise: push {popped pc, rdata, 0} into ibuf.

**ADEF**
- Condition: fetch_pc[1:0] ≠ 0, ~halted, live inflight (inflight − cancel_cnt) = 0, ibuf not full, no redirect.
- Action: push {fetch_pc, 32'h0, 1} into ibuf and set halted. No memory request is issued.
- halted blocks all fetch until the next redirect.

**Consume**
- fs_to_ds_valid = ibuf_count ≠ 0.
- The head is popped on fs_to_ds_valid & ds_allow_in.

**Redirect** (highest priority)
- fetch_pc ← redirect_pc; ibuf emptied; halted ← 0.
- cancel_cnt ← inflight − (data_ok ? 1 : 0), the number of requests still outstanding after this cycle.
- A pop requested by ID in the same cycle is ignored.
- No request is issued in the redirect cycle.

## Timing
- Reset values:
  - inst_sram_req = 0 while reset is asserted, 1 from the first cycle after release.
  - inst_sram_addr = RESET_PC.
  - fs_to_ds_valid = 0; fs_pc = 0; fs_inst = 0; fs_ex_adef = 0.
  - inflight = 0, cancel_cnt = 0, halted = 0, ibuf empty.
- Latency: addr_ok at cycle t lets the next sequential request assert at t+1 (req itself is combinational, so back-to-back acceptance is possible). data_ok at cycle t → fs_to_ds_valid at t+1 (no bypass).
- Throughput: one instruction per cycle sustained when the memory sustains it.
- Simultaneous events in one cycle:
  - ibuf push and pop: both happen, count unchanged.
  - addr_ok and data_ok: inflight unchanged, pc_fifo pushes and pops.
  - redirect and data_ok: the data is dropped.
- A data_ok while inflight = 0 is a protocol violation; it is ignored and state is unchanged.
- ibuf full: no data loss is possible, because issue credit was withheld.
- Reset mid-operation: all counters and buffers clear asynchronously. The memory side is reset by the same signal, so no late responses are expected.

## Test plan
- Reset release, memory always returns addr_ok and one-cycle data_ok, ds_allow_in=1 → addresses 0x1C000000, …04, …08 issued back to back; fs_pc sequence identical; one instruction per cycle.
- MAX_OUTSTANDING=2, data_ok withheld → exactly two requests accepted (0x1C000000, 0x1C000004); req stays low until the first data_ok.
- ds_allow_in=0, IBUF_DEPTH=4 → at most 4 requests counted against credit; req drops; contents delivered in order once ds_allow_in=1.
- Two requests in flight, redirect_valid with redirect_pc=0x1C000100 → cancel_cnt=2; the next two data_ok are dropped; the first fs_pc delivered is 0x1C000100.
- Redirect in the same cycle as data_ok with inflight=2 → cancel_cnt=1; one further response dropped.
- redirect_pc=0x1C000102 → no memory request; one entry fs_ex_adef=1, fs_pc=0x1C000102, fs_inst=0; then halted until a redirect to 0x1C000200 resumes fetch.
